sub_4_seq: RTL and testbench

- Bit-serial ripple-borrow subtractor that computes diff = a − b − borrow_in over WIDTH clock cycles, one bit per cycle, LSB first.
- It is the inverse-direction companion of the team's combinational 4-bit adder. Operands and results use the same a_i/b_i/c_i in, *_0 out interface style.
- A start/done handshake lets a stimulus or controller block issue operations back-to-back and collect the results.
- It sits beside the adder in the lab datapath and is checked against the adder: (diff + b + borrow_in) mod 2^WIDTH == a.

---
 rtl/sub_4_seq_pkg.sv | 12 +
 rtl/full_sub_1.sv | 13 +
 rtl/sub_4_seq.sv | 141 ++++++++++++++
 tb/tb_sub_4_seq.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/sub_4_seq_pkg.sv
// Shared definitions for the bit-serial subtractor: default width and FSM state codes.
package sub_4_seq_pkg;

   localparam int SUB_WIDTH_DEF = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/full_sub_1.sv
// Combinational 1-bit full subtractor: d = a - b - bin, bout is the borrow out.
module full_sub_1 (
   input  logic a_i,
   input  logic b_i,
   input  logic bin_i,
   output logic d_o,
   output logic bout_o
);

   assign d_o    = a_i ^ b_i ^ bin_i;
   assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);

endmodule

// File: rtl/sub_4_seq.sv
// Bit-serial ripple-borrow subtractor: diff = a - b - c over WIDTH cycles, LSB first,
// with a start/done handshake and registered result, borrow and signed-overflow flags.
module sub_4_seq
   import sub_4_seq_pkg::*;
#(
   parameter int WIDTH = SUB_WIDTH_DEF
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             c_i,
   output logic             busy_0,
   output logic             done_0,
   output logic [WIDTH-1:0] diff_0,
   output logic             borrow_0,
   output logic             ovf_0
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             br_q, br_d;
   logic             a_msb_q, a_msb_d;
   logic             b_msb_q, b_msb_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             borrow_q, borrow_d;
   logic             ovf_q, ovf_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic d_bit, bout_bit;

   full_sub_1 u_cell (
      .a_i   (a_sh_q[0]),
      .b_i   (b_sh_q[0]),
      .bin_i (br_q),
      .d_o   (d_bit),
      .bout_o(bout_bit)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      res_d    = res_q;
      br_d     = br_q;
      a_msb_d  = a_msb_q;
      b_msb_d  = b_msb_q;
      diff_d   = diff_q;
      borrow_d = borrow_q;
      ovf_d    = ovf_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            busy_d = 1'b0;
            if (start_i) begin
               a_sh_d  = a_i;
               b_sh_d  = b_i;
               br_d    = c_i;
               a_msb_d = a_i[WIDTH-1];
               b_msb_d = b_i[WIDTH-1];
               res_d   = '0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            res_d  = {d_bit, res_q[WIDTH-1:1]};
            a_sh_d = a_sh_q >> 1;
            b_sh_d = b_sh_q >> 1;
            br_d   = bout_bit;
            cnt_d  = cnt_q + CW'(1);
            // Results are published only once the MSB has been processed.
            if (cnt_q == LAST_BIT) begin
               diff_d   = {d_bit, res_q[WIDTH-1:1]};
               borrow_d = bout_bit;
               ovf_d    = (a_msb_q ^ b_msb_q) & (d_bit ^ a_msb_q);
               done_d   = 1'b1;
               state_d  = ST_DONE;
            end
         end
         ST_DONE: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         res_q    <= '0;
         br_q     <= 1'b0;
         a_msb_q  <= 1'b0;
         b_msb_q  <= 1'b0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
         ovf_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         res_q    <= res_d;
         br_q     <= br_d;
         a_msb_q  <= a_msb_d;
         b_msb_q  <= b_msb_d;
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
         ovf_q    <= ovf_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign busy_0   = busy_q;
   assign done_0   = done_q;
   assign diff_0   = diff_q;
   assign borrow_0 = borrow_q;
   assign ovf_0    = ovf_q;

endmodule

// File: tb/tb_sub_4_seq.sv
// Self-checking bench for sub_4_seq: directed cases, handshake/reset scenarios,
// randomized operations and an exhaustive sweep against an arithmetic model.
module tb_sub_4_seq;

   localparam int W = 4;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a, b;
   logic         c;
   logic         busy, done;
   logic [W-1:0] diff;
   logic         borrow, ovf;

   int errors = 0;
   int checks = 0;
   int prev_diff = 0;

   sub_4_seq #(.WIDTH(W)) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .start_i (start),
      .a_i     (a),
      .b_i     (b),
      .c_i     (c),
      .busy_0  (busy),
      .done_0  (done),
      .diff_0  (diff),
      .borrow_0(borrow),
      .ovf_0   (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Must be called at a falling edge; returns at the falling edge after the DONE cycle.
   task automatic run_op(input int ta, input int tb_v, input int tc, input string tag);
      int ediff, eborrow, eovf, dmsb, amsb, bmsb;
      ediff   = (ta - tb_v - tc) & ((1 << W) - 1);
      eborrow = (ta < tb_v + tc) ? 1 : 0;
      amsb    = (ta >> (W - 1)) & 1;
      bmsb    = (tb_v >> (W - 1)) & 1;
      dmsb    = (ediff >> (W - 1)) & 1;
      eovf    = (amsb != bmsb && dmsb != amsb) ? 1 : 0;
      a = W'(ta); b = W'(tb_v); c = tc[0]; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      a = W'($urandom); b = W'($urandom); c = 1'($urandom);
      chk({tag, "_busy_accept"}, int'(busy), 1);
      for (int j = 1; j < W; j++) begin
         @(negedge clk);
         chk({tag, "_done_early"}, int'(done), 0);
         chk({tag, "_diff_hold"}, int'(diff), prev_diff);
      end
      @(negedge clk);
      chk({tag, "_done"}, int'(done), 1);
      chk({tag, "_busy_done"}, int'(busy), 1);
      chk({tag, "_diff"}, int'(diff), ediff);
      chk({tag, "_borrow"}, int'(borrow), eborrow);
      chk({tag, "_ovf"}, int'(ovf), eovf);
      chk({tag, "_adder_xchk"}, (int'(diff) + tb_v + tc) & ((1 << W) - 1), ta);
      @(negedge clk);
      chk({tag, "_done_clear"}, int'(done), 0);
      chk({tag, "_busy_clear"}, int'(busy), 0);
      prev_diff = ediff;
      $display("op %s a=%0d b=%0d c=%0d -> diff=%0d borrow=%0d ovf=%0d", tag, ta, tb_v, tc,
               diff, borrow, ovf);
   endtask

   initial begin
      int done_idx[$];
      int saw_done;
      int saw_busy;
      rst_n = 1'b0; start = 1'b0; a = '0; b = '0; c = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_diff", int'(diff), 0);
      chk("rst_borrow", int'(borrow), 0);
      chk("rst_ovf", int'(ovf), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed cases
      run_op(5, 3, 0, "basic");
      run_op(3, 5, 0, "negative");
      run_op(0, 0, 1, "borrow_in");
      run_op(8, 1, 0, "signed_ovf");
      run_op(15, 15, 1, "all_ones");

      // Randomized operations
      for (int i = 0; i < 16; i++)
         run_op(int'($urandom_range(15)), int'($urandom_range(15)), int'($urandom_range(1)), "rand");

      // start held high: one accept every W+2 cycles, one done pulse each
      a = 4'd9; b = 4'd4; c = 1'b0; start = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done) done_idx.push_back(i);
      end
      chk("hold_done_count", done_idx.size(), 3);
      for (int i = 0; i < done_idx.size(); i++)
         chk("hold_done_pos", done_idx[i], (W) + i * (W + 2));
      start = 1'b0;
      repeat (W + 3) @(negedge clk);
      chk("hold_diff", int'(diff), 5);
      chk("hold_idle", int'(busy), 0);
      prev_diff = 5;

      // Reset in the middle of SHIFT
      a = 4'd14; b = 4'd3; c = 1'b0; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_done", int'(done), 0);
      chk("midrst_diff", int'(diff), 0);
      chk("midrst_borrow", int'(borrow), 0);
      chk("midrst_ovf", int'(ovf), 0);
      saw_done = 0; saw_busy = 0;
      for (int i = 0; i < 2 * W; i++) begin
         @(negedge clk);
         if (done) saw_done = 1;
         if (busy) saw_busy = 1;
      end
      chk("midrst_no_done", saw_done, 0);
      chk("midrst_stay_idle", saw_busy, 0);
      prev_diff = 0;

      // Exhaustive sweep of {a, b, c}
      for (int i = 0; i < 512; i++)
         run_op((i >> 5) & 15, (i >> 1) & 15, i & 1, "sweep");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
